// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths and read-response tag for sram_arbiter.
// Build option SRAM_ARB_RR_EN selects round-robin arbitration.
package sram_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 34;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } rsp_tag_t;

endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: combinational one-hot grant for the two SRAM requesters.
// Lock owner overrides; on contention the port other than `last` wins.
module sram_arb_grant (
    input  logic       valid_0,
    input  logic       valid_1,
    input  logic       locked,
    input  logic       owner,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (locked) begin
            if (owner) grant[1] = valid_1;
            else       grant[0] = valid_0;
        end else if (valid_0 && valid_1) begin
            if (last) grant = 2'b01;
            else      grant = 2'b10;
        end else begin
            grant = {valid_1, valid_0};
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port node SRAM between two requesters.
// Define SRAM_ARB_RR_EN for round-robin; default is fixed port-0 priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid_0,
    output logic                  o_req_ready_0,
    input  logic                  i_req_write_0,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_0,
    input  logic [DATA_WIDTH-1:0] i_req_data_0,
    input  logic                  i_req_lock_0,
    output logic                  o_rsp_valid_0,
    output logic [DATA_WIDTH-1:0] o_rsp_data_0,
    input  logic                  i_req_valid_1,
    output logic                  o_req_ready_1,
    input  logic                  i_req_write_1,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_1,
    input  logic [DATA_WIDTH-1:0] i_req_data_1,
    input  logic                  i_req_lock_1,
    output logic                  o_rsp_valid_1,
    output logic [DATA_WIDTH-1:0] o_rsp_data_1,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_write,
    output logic [DATA_WIDTH-1:0] o_sram_data,
    input  logic [DATA_WIDTH-1:0] i_sram_data
);

    logic [1:0]            grant;
    logic                  accept;
    port_id_t              sel;
    logic                  sel_write;
    logic                  sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  locked;
    port_id_t              owner;
    port_id_t              last;
    rsp_tag_t              tag_1;
    rsp_tag_t              tag_2;
    logic                  hit_0;
    logic                  hit_1;
    logic [DATA_WIDTH-1:0] hold_0;
    logic [DATA_WIDTH-1:0] hold_1;

    sram_arb_grant u_grant (
        .valid_0 (i_req_valid_0),
        .valid_1 (i_req_valid_1),
        .locked  (locked),
        .owner   (owner),
        .last    (last),
        .grant   (grant)
    );

    assign o_req_ready_0 = grant[0] & ~i_rst;
    assign o_req_ready_1 = grant[1] & ~i_rst;
    assign accept        = (grant[0] | grant[1]) & ~i_rst;
    assign sel           = grant[1];

    assign sel_write = sel ? i_req_write_1 : i_req_write_0;
    assign sel_lock  = sel ? i_req_lock_1  : i_req_lock_0;
    assign sel_addr  = sel ? i_req_addr_1  : i_req_addr_0;
    assign sel_data  = sel ? i_req_data_1  : i_req_data_0;

`ifdef SRAM_ARB_RR_EN
    // Transfers made under an active lock leave the pointer alone.
    always_ff @(posedge i_clk) begin
        if (i_rst)                  last <= 1'b1;
        else if (accept && !locked) last <= sel;
    end
`else
    assign last = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sram_write <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_data  <= '0;
            locked       <= 1'b0;
            owner        <= 1'b0;
            tag_1        <= '0;
            tag_2        <= '0;
        end else begin
            o_sram_write <= accept & sel_write;
            if (accept) begin
                o_sram_addr <= sel_addr;
                o_sram_data <= sel_data;
                locked      <= sel_lock;
                owner       <= sel;
            end
            tag_1 <= '{valid: accept & ~sel_write, id: sel};
            tag_2 <= tag_1;
        end
    end

    // tag_2 lines up with the cycle the SRAM drives the read word.
    assign hit_0 = tag_2.valid & (tag_2.id == 1'b0) & ~i_rst;
    assign hit_1 = tag_2.valid & (tag_2.id == 1'b1) & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_0 <= '0;
            hold_1 <= '0;
        end else begin
            if (hit_0) hold_0 <= i_sram_data;
            if (hit_1) hold_1 <= i_sram_data;
        end
    end

    assign o_rsp_valid_0 = hit_0;
    assign o_rsp_valid_1 = hit_1;
    assign o_rsp_data_0  = i_rst ? '0 : (hit_0 ? i_sram_data : hold_0);
    assign o_rsp_data_1  = i_rst ? '0 : (hit_1 ? i_sram_data : hold_1);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed table plus random traffic against a
// transaction-level model of the arbiter and an SRAM behavioural array.
module tb_sram_arbiter;

    localparam int AW = 4;
    localparam int DW = 34;

    typedef struct packed {
        logic          rst;
        logic          v0;
        logic          w0;
        logic          l0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic          w1;
        logic          l1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          chk;
        logic          er0;
        logic          er1;
        logic          ev0;
        logic          ev1;
        logic          chkd;
        logic          dp;
        logic [DW-1:0] ed;
    } vec_t;

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_t;

    localparam logic [DW-1:0] D3 = {8'd100, 8'd0, 8'd0, 10'd245};
    localparam logic [DW-1:0] D5 = {8'd9, 8'd8, 8'd7, 10'd6};
    localparam logic [DW-1:0] D7 = {8'd1, 8'd2, 8'd3, 10'd695};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_0 = 1'b0;
    logic          req_ready_0;
    logic          req_write_0 = 1'b0;
    logic [AW-1:0] req_addr_0 = '0;
    logic [DW-1:0] req_data_0 = '0;
    logic          req_lock_0 = 1'b0;
    logic          rsp_valid_0;
    logic [DW-1:0] rsp_data_0;
    logic          req_valid_1 = 1'b0;
    logic          req_ready_1;
    logic          req_write_1 = 1'b0;
    logic [AW-1:0] req_addr_1 = '0;
    logic [DW-1:0] req_data_1 = '0;
    logic          req_lock_1 = 1'b0;
    logic          rsp_valid_1;
    logic [DW-1:0] rsp_data_1;
    logic [AW-1:0] sram_addr;
    logic          sram_write;
    logic [DW-1:0] sram_data;
    logic [DW-1:0] sram_q;

    logic [DW-1:0] smem [16];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0] m_mem [16];
    rsp_t          m_q [$];
    bit            m_locked;
    int            m_owner;
    int            m_last;
    logic [DW-1:0] m_hold [2];
    bit            m_known;
    logic          m_pw;
    logic [AW-1:0] m_pa;
    logic [DW-1:0] m_pd;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid_0 (req_valid_0),
        .o_req_ready_0 (req_ready_0),
        .i_req_write_0 (req_write_0),
        .i_req_addr_0  (req_addr_0),
        .i_req_data_0  (req_data_0),
        .i_req_lock_0  (req_lock_0),
        .o_rsp_valid_0 (rsp_valid_0),
        .o_rsp_data_0  (rsp_data_0),
        .i_req_valid_1 (req_valid_1),
        .o_req_ready_1 (req_ready_1),
        .i_req_write_1 (req_write_1),
        .i_req_addr_1  (req_addr_1),
        .i_req_data_1  (req_data_1),
        .i_req_lock_1  (req_lock_1),
        .o_rsp_valid_1 (rsp_valid_1),
        .o_rsp_data_1  (rsp_data_1),
        .o_sram_addr   (sram_addr),
        .o_sram_write  (sram_write),
        .o_sram_data   (sram_data),
        .i_sram_data   (sram_q)
    );

    // Registered-output single-port SRAM.
    always @(posedge clk) begin
        if (sram_write) smem[sram_addr] <= sram_data;
        sram_q <= smem[sram_addr];
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return {8'(i * 3), 8'(i + 17), 8'(i ^ 8'h5a), 10'(i * 37 + 1)};
    endfunction

    function automatic vec_t req(input bit p, input bit w,
                                 input int a, input logic [DW-1:0] d,
                                 input bit l, input vec_t b);
        vec_t r;
        r = b;
        if (p) begin
            r.v1 = 1'b1; r.w1 = w; r.a1 = AW'(a); r.d1 = d; r.l1 = l;
        end else begin
            r.v0 = 1'b1; r.w0 = w; r.a0 = AW'(a); r.d0 = d; r.l0 = l;
        end
        return r;
    endfunction

    function automatic vec_t ex(input vec_t b, input bit r0, input bit r1,
                                input bit q0, input bit q1);
        vec_t r;
        r = b;
        r.chk = 1'b1; r.er0 = r0; r.er1 = r1; r.ev0 = q0; r.ev1 = q1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Rule-level arbitration: lock first, then policy on contention.
    function automatic int pick(input vec_t v);
        if (v.rst) return -1;
        if (m_locked) begin
            if (m_owner == 0) return v.v0 ? 0 : -1;
            return v.v1 ? 1 : -1;
        end
        if (v.v0 && v.v1) begin
`ifdef SRAM_ARB_RR_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        if (v.v0) return 0;
        if (v.v1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_locked = 1'b0;
        m_owner = 0;
        m_last = 1;
        m_hold[0] = '0;
        m_hold[1] = '0;
        m_pw = 1'b0;
        m_pa = '0;
        m_pd = '0;
        m_known = 1'b1;
    endtask

    task automatic step(input vec_t v);
        int g;
        bit due;
        bit ev [2];
        logic [DW-1:0] ed [2];
        logic [DW-1:0] got_d [2];
        bit w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        rst = v.rst;
        req_valid_0 = v.v0; req_write_0 = v.w0; req_lock_0 = v.l0;
        req_addr_0 = v.a0; req_data_0 = v.d0;
        req_valid_1 = v.v1; req_write_1 = v.w1; req_lock_1 = v.l1;
        req_addr_1 = v.a1; req_data_1 = v.d1;
        #1;
        g = pick(v);
        due = (m_q.size() > 0) && (m_q[0].due == cyc);
        for (int p = 0; p < 2; p++) begin
            ev[p] = !v.rst && due && (m_q[0].port == p);
            ed[p] = ev[p] ? m_q[0].data : m_hold[p];
        end
        got_d[0] = rsp_data_0;
        got_d[1] = rsp_data_1;
        chk("ready_0", 64'(req_ready_0), 64'(g == 0));
        chk("ready_1", 64'(req_ready_1), 64'(g == 1));
        chk("rsp_valid_0", 64'(rsp_valid_0), 64'(ev[0]));
        chk("rsp_valid_1", 64'(rsp_valid_1), 64'(ev[1]));
        if (!v.rst && m_known) begin
            chk("rsp_data_0", 64'(rsp_data_0), 64'(ed[0]));
            chk("rsp_data_1", 64'(rsp_data_1), 64'(ed[1]));
            chk("sram_write", 64'(sram_write), 64'(m_pw));
            chk("sram_addr", 64'(sram_addr), 64'(m_pa));
            chk("sram_data", 64'(sram_data), 64'(m_pd));
        end
        if (v.chk) begin
            chk("tbl_ready_0", 64'(req_ready_0), 64'(v.er0));
            chk("tbl_ready_1", 64'(req_ready_1), 64'(v.er1));
            chk("tbl_rsp_valid_0", 64'(rsp_valid_0), 64'(v.ev0));
            chk("tbl_rsp_valid_1", 64'(rsp_valid_1), 64'(v.ev1));
            if (v.chkd)
                chk("tbl_rsp_data", 64'(got_d[v.dp]), 64'(v.ed));
        end
        if (v.rst) begin
            model_reset();
        end else begin
            if (due) begin
                m_hold[m_q[0].port] = m_q[0].data;
                void'(m_q.pop_front());
            end
            m_pw = 1'b0;
            if (g >= 0) begin
                w = (g == 1) ? v.w1 : v.w0;
                a = (g == 1) ? v.a1 : v.a0;
                d = (g == 1) ? v.d1 : v.d0;
                m_pw = w;
                m_pa = a;
                m_pd = d;
                if (w) m_mem[a] = d;
                else   m_q.push_back('{due: cyc + 2, port: g, data: m_mem[a]});
                if (!m_locked) m_last = g;
                m_locked = (g == 1) ? v.l1 : v.l0;
                m_owner = g;
            end
        end
        cyc++;
    endtask

    initial begin
        vec_t tbl [$];
        vec_t t;
        vec_t nil;
        nil = '0;
        m_known = 1'b0;
        for (int i = 0; i < 16; i++) begin
            smem[i] = init_word(i);
            m_mem[i] = init_word(i);
        end

        t = nil; t.rst = 1'b1;
        tbl.push_back(ex(req(0, 0, 0, '0, 0, req(1, 0, 1, '0, 0, t)),
                         0, 0, 0, 0));
        tbl.push_back(ex(t, 0, 0, 0, 0));
        tbl.push_back(ex(nil, 0, 0, 0, 0));
        tbl.push_back(ex(req(0, 1, 3, D3, 0, nil), 1, 0, 0, 0));
        tbl.push_back(ex(req(0, 0, 3, '0, 0, nil), 1, 0, 0, 0));
        tbl.push_back(ex(nil, 0, 0, 0, 0));
        t = ex(nil, 0, 0, 1, 0); t.chkd = 1'b1; t.dp = 1'b0; t.ed = D3;
        tbl.push_back(t);
        tbl.push_back(ex(req(1, 0, 0, '0, 0, nil), 0, 1, 0, 0));
        // Contention: both ports reading addresses 1 and 2.
        t = req(0, 0, 1, '0, 0, req(1, 0, 2, '0, 0, nil));
`ifdef SRAM_ARB_RR_EN
        tbl.push_back(ex(t, 1, 0, 0, 0));
        tbl.push_back(ex(t, 0, 1, 0, 1));
        tbl.push_back(ex(t, 1, 0, 1, 0));
        tbl.push_back(ex(t, 0, 1, 0, 1));
        tbl.push_back(ex(nil, 0, 0, 1, 0));
        tbl.push_back(ex(nil, 0, 0, 0, 1));
`else
        tbl.push_back(ex(t, 1, 0, 0, 0));
        tbl.push_back(ex(t, 1, 0, 0, 1));
        tbl.push_back(ex(t, 1, 0, 1, 0));
        tbl.push_back(ex(t, 1, 0, 1, 0));
        tbl.push_back(ex(nil, 0, 0, 1, 0));
        tbl.push_back(ex(nil, 0, 0, 1, 0));
`endif
        tbl.push_back(ex(nil, 0, 0, 0, 0));
        // Lock held by port 1 across a read-modify-write of addr 5.
        tbl.push_back(ex(req(1, 0, 5, '0, 1, nil), 0, 1, 0, 0));
        tbl.push_back(ex(req(0, 0, 4, '0, 0, req(1, 0, 6, '0, 1, nil)),
                         0, 1, 0, 0));
        tbl.push_back(ex(req(0, 0, 4, '0, 0, req(1, 1, 5, D5, 0, nil)),
                         0, 1, 0, 1));
        tbl.push_back(ex(req(0, 0, 4, '0, 0, req(1, 0, 6, '0, 0, nil)),
                         1, 0, 0, 1));
        tbl.push_back(ex(nil, 0, 0, 0, 0));
        tbl.push_back(ex(nil, 0, 0, 1, 0));
        // Write then immediate read of the same address.
        tbl.push_back(ex(req(0, 1, 7, D7, 0, nil), 1, 0, 0, 0));
        tbl.push_back(ex(req(1, 0, 7, '0, 0, nil), 0, 1, 0, 0));
        tbl.push_back(ex(nil, 0, 0, 0, 0));
        t = ex(nil, 0, 0, 0, 1); t.chkd = 1'b1; t.dp = 1'b1; t.ed = D7;
        tbl.push_back(t);
        // Reset right after a locked read is accepted.
        tbl.push_back(ex(req(0, 0, 1, '0, 1, nil), 1, 0, 0, 0));
        t = req(1, 0, 2, '0, 0, nil); t.rst = 1'b1;
        tbl.push_back(ex(t, 0, 0, 0, 0));
        tbl.push_back(ex(req(1, 0, 2, '0, 0, nil), 0, 1, 0, 0));
        tbl.push_back(ex(nil, 0, 0, 0, 0));
        tbl.push_back(ex(nil, 0, 0, 0, 1));
        // Back-to-back reads from port 1.
        for (int i = 0; i < 8; i++)
            tbl.push_back(ex(req(1, 0, i, '0, 0, nil), 0, 1, 0, i >= 2));
        tbl.push_back(ex(nil, 0, 0, 0, 1));
        tbl.push_back(ex(nil, 0, 0, 0, 1));
        tbl.push_back(ex(nil, 0, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        for (int n = 0; n < 600; n++) begin
            t = nil;
            t.rst = ($urandom_range(0, 59) == 0);
            t.v0 = 1'($urandom_range(0, 1));
            t.w0 = 1'($urandom_range(0, 1));
            t.l0 = ($urandom_range(0, 3) == 0);
            t.a0 = AW'($urandom_range(0, 15));
            t.d0 = {2'($urandom), 32'($urandom)};
            t.v1 = 1'($urandom_range(0, 1));
            t.w1 = 1'($urandom_range(0, 1));
            t.l1 = ($urandom_range(0, 3) == 0);
            t.a1 = AW'($urandom_range(0, 15));
            t.d1 = {2'($urandom), 32'($urandom)};
            step(t);
        end
        step(nil);
        step(nil);
        step(nil);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
